// File: rtl/ps2_pkg.sv
// Shared PS/2 types, frame constants and command bytes for the host transmitter
// and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INHIBIT,
    SEND,
    WAIT_IDLE
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // PS/2 parity bit: makes the total count of ones in data+parity odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pad plus a history flop for
// edge detection. Resets to the idle (released, high) line level so that
// leaving reset never produces a spurious edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // synchronizer chain and one cycle of history for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign fall  = prev_q & ~sync2_q;
  assign rise  = ~prev_q & sync2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out an 11-bit frame on device-generated clock falls and samples the
// device ACK. Pads are open-drain: *_oe=1 pulls the line low.
//
//   state     | meaning
//   IDLE      | ready for a command byte, lines released
//   INHIBIT   | clock held low; start bit presented in the final cycle
//   SEND      | device clocks the frame out; data follows the frame shifter
//   WAIT_IDLE | frame done, waiting for device to release both lines
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int ICW = $clog2(INHIBIT_CYCLES);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam int BCW = $clog2(PS2_FRAME_BITS);

  localparam logic [ICW-1:0] INH_LOAD = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [TCW-1:0] TOUT_TC  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(PS2_FRAME_BITS - 1);

  ps2_state_e state_q, state_d;

  logic [ICW-1:0] icnt_q;
  logic [TCW-1:0] tcnt_q;
  logic [BCW-1:0] bitcnt_q;
  logic [PS2_FRAME_BITS-1:0] frame_q;
  logic ack_err_q;

  logic clk_lvl, clk_fall, clk_rise;
  logic data_lvl, data_fall, data_rise;
  logic unused_edges;

  logic accept;
  logic inh_tc;
  logic tout_hit;
  logic last_fall;

  ps2_sync_edge u_sync_clk (
    .clk    (clk),
    .resetn (resetn),
    .din    (ps2_clk_i),
    .level  (clk_lvl),
    .fall   (clk_fall),
    .rise   (clk_rise)
  );

  ps2_sync_edge u_sync_data (
    .clk    (clk),
    .resetn (resetn),
    .din    (ps2_data_i),
    .level  (data_lvl),
    .fall   (data_fall),
    .rise   (data_rise)
  );

  assign unused_edges = &{1'b0, clk_rise, data_fall, data_rise};

  assign busy      = (state_q != IDLE);
  assign tx_ready  = ~busy;
  assign accept    = tx_valid & tx_ready;
  assign inh_tc    = (icnt_q == '0);
  assign tout_hit  = ((state_q == SEND) || (state_q == WAIT_IDLE)) && (tcnt_q == TOUT_TC);
  assign last_fall = clk_fall && (bitcnt_q == BIT_LAST);

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state and pad/status outputs; timeout forces lines released same cycle
  always_comb begin
    state_d     = state_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    ack_err     = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) state_d = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = inh_tc;
        if (inh_tc) state_d = SEND;
      end
      SEND: begin
        if (tout_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          ps2_data_oe = ~frame_q[0];
          if (last_fall) state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (tout_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (clk_lvl && data_lvl) begin
          done    = 1'b1;
          ack_err = ack_err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // inhibit down-counter, timeout counter, frame shifter and ACK capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      icnt_q    <= '0;
      tcnt_q    <= '0;
      bitcnt_q  <= '0;
      frame_q   <= '1;
      ack_err_q <= 1'b0;
    end else begin
      if (accept) begin
        // bit 0 is the start bit; ones shift in behind the stop bit
        frame_q <= {1'b1, odd_parity(tx_data), tx_data, 1'b0};
        icnt_q  <= INH_LOAD;
      end else if (state_q == INHIBIT && !inh_tc) begin
        icnt_q <= icnt_q - ICW'(1);
      end

      if (state_q == INHIBIT) begin
        tcnt_q   <= '0;
        bitcnt_q <= '0;
      end else if (state_q == SEND || state_q == WAIT_IDLE) begin
        if (tcnt_q != TOUT_TC) tcnt_q <= tcnt_q + TCW'(1);
      end

      if (state_q == SEND && clk_fall) begin
        if (bitcnt_q != BIT_LAST) begin
          bitcnt_q <= bitcnt_q + BCW'(1);
          frame_q  <= {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
        end else begin
          ack_err_q <= data_lvl;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model that
// clocks frames at a 40-cycle half-period and optionally ACKs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic       clk;
  logic       resetn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_err, timeout;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pad, ps2_data_pad;

  int n_cmp = 0;
  int n_mis = 0;

  int inh_cnt, inh_dcnt, inh_dlast;
  int acc_cnt;
  bit bad_ov, bad_ae;

  assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_pad),
    .ps2_data_i  (ps2_data_pad),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end, expected summary");
    $fatal(1, "watchdog");
  end

  // monitor: inhibit shape per transfer, accept count, output invariants
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      inh_cnt = 0; inh_dcnt = 0; inh_dlast = 0;
      acc_cnt = acc_cnt + 1;
    end else if (ps2_clk_oe) begin
      inh_cnt = inh_cnt + 1;
      if (ps2_data_oe) begin
        inh_dcnt  = inh_dcnt + 1;
        inh_dlast = inh_cnt;
      end
    end
    if (done && timeout) bad_ov = 1'b1;
    if (!done && ack_err) bad_ae = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    wait_cyc(1);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
  endtask

  // device side: wait for request-to-send, clock nclk bits (sampling on the
  // rising edge), and for a full frame drive the ACK bit on the 11th clock
  task automatic dev_frame(input int nclk, input bit do_ack, output logic [9:0] bits);
    bit found;
    found = 1'b0;
    bits  = '0;
    for (int i = 0; i < 100; i++) begin
      wait_cyc(1);
      if (ps2_clk_pad && !ps2_data_pad) begin
        found = 1'b1;
        break;
      end
    end
    chk("rts_seen", 32'(found), 32'd1);
    if (!found) return;
    for (int k = 0; k < nclk && k < 10; k++) begin
      wait_cyc(40);
      dev_clk_low = 1'b1;
      wait_cyc(40);
      bits[k] = ps2_data_pad;
      dev_clk_low = 1'b0;
    end
    if (nclk > 10) begin
      wait_cyc(20);
      dev_data_low = do_ack;
      wait_cyc(20);
      dev_clk_low = 1'b1;
      wait_cyc(40);
      dev_data_low = 1'b0;
      wait_cyc(5);
      dev_clk_low = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_ae);
    bit   seen;
    logic ae;
    seen = 1'b0;
    ae   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        ae   = ack_err;
        break;
      end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_ack_err"}, 32'(ae), 32'(exp_ae));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit do_ack,
                           input logic [9:0] exp_bits);
    logic [9:0] bits;
    send_byte(d);
    dev_frame(11, do_ack, bits);
    chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    wait_done(tag, ~do_ack);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [9:0] bits;
    int  n;
    bit  seen;

    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    inh_cnt = 0; inh_dcnt = 0; inh_dlast = 0; acc_cnt = 0;
    bad_ov = 1'b0; bad_ae = 1'b0;

    #23;
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    resetn = 1'b1;
    wait_cyc(3);

    // 0xED: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1
    send_byte(PS2_CMD_SET_LED);
    dev_frame(11, 1'b1, bits);
    chk("ed_inhibit_len", 32'(inh_cnt), 32'd8);
    chk("ed_inhibit_data_cycles", 32'(inh_dcnt), 32'd1);
    chk("ed_inhibit_data_last", 32'(inh_dlast), 32'd8);
    chk("ed_bits", 32'(bits), 32'h3ED);
    wait_done("ed", 1'b0);
    @(negedge clk);
    chk("ed_ready_after", 32'(tx_ready), 32'd1);

    // parity boundaries
    run_frame("x00", 8'h00, 1'b1, 10'h300);
    run_frame("x01", 8'h01, 1'b1, 10'h201);

    // device never pulls data low in the ACK slot
    run_frame("noack", PS2_ACK, 1'b0, 10'h3FA);

    // device never clocks: count SEND cycles up to and including the pulse
    send_byte(8'h55);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy && !ps2_clk_oe) n++;
      if (timeout) begin
        seen = 1'b1;
        chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("to_no_done", 32'(done), 32'd0);
        break;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_send_cycles", 32'(n), 32'd2000);
    @(negedge clk);
    chk("to_ready_after", 32'(tx_ready), 32'd1);
    chk("to_timeout_one_cycle", 32'(timeout), 32'd0);

    // async reset after the 5th fall: data[4] of 0xED is 0, so data is driven
    send_byte(PS2_CMD_SET_LED);
    dev_frame(5, 1'b1, bits);
    chk("mid_bits", 32'(bits[4:0]), 32'h0D);
    @(negedge clk);
    chk("mid_data_oe_before", 32'(ps2_data_oe), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(3);
    run_frame("ff", PS2_CMD_RESET, 1'b1, 10'h3FF);

    // tx_valid held high; frame in flight must ignore tx_data changes
    wait_cyc(1);
    acc_cnt  = 0;
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) wait_cyc(1);
    tx_data = 8'hF5;
    dev_frame(11, 1'b1, bits);
    chk("f4_bits", 32'(bits), 32'h2F4);
    wait_done("f4", 1'b0);
    @(posedge clk); #1;
    chk("b2b_accepts_during_first", 32'(acc_cnt), 32'd1);
    chk("b2b_ready_after_done", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_accepts_after", 32'(acc_cnt), 32'd2);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_frame(11, 1'b1, bits);
    chk("f5_bits", 32'(bits), 32'h3F5);
    wait_done("f5", 1'b0);

    chk("done_timeout_overlap", 32'(bad_ov), 32'd0);
    chk("ack_err_without_done", 32'(bad_ae), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
